jam_ctrl: RTL and testbench
===========================

JAM_CTRL -- requirements
Module: jam_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 20'd1048575, is the maximum number of RUN cycles allowed before the watchdog aborts the run.
REQ-002 CLK  input  1  single clock, all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a load-and-run job; sampled in IDLE only.
REQ-005 in_valid  input  1  cost-stream word valid.
REQ-006 in_ready  output  1  controller accepts a cost word this cycle.
REQ-007 in_cost  input  7  cost word; words arrive row-major, index = W*8+J.
REQ-008 jam_rst  output  1  reset drive to the JAM engine.
REQ-009 jam_W  input  3  worker index from the engine.
REQ-010 jam_J  input  3  job index from the engine.
REQ-011 jam_Cost  output  7  cost lookup returned to the engine.
REQ-012 jam_MinCost  input  10  engine result.
REQ-013 jam_MatchCount  input  4  engine result.
REQ-014 jam_Valid  input  1  engine done flag.
REQ-015 res_valid  output  1  result available.
REQ-016 res_ready  input  1  result consumer ready.
REQ-017 res_min_cost  output  10  captured MinCost.
REQ-018 res_match_count  output  4  captured MatchCount.
REQ-019 res_timeout  output  1  the run was aborted by the watchdog.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, RUN and RESULT, held in a registered state.
REQ-022 IDLE: start=1 -> LOAD, clearing the 6-bit load index; in_valid is ignored and in_ready=0.
REQ-023 LOAD: in_ready=1; each cycle with in_valid=1 writes in_cost to table[idx] and increments idx; gaps in in_valid stall without error.
REQ-024 Acceptance of word 63 (idx=63 with in_valid=1) SHALL move the FSM to RUN on that edge; in_ready is 0 in the following cycle.
REQ-025 The table SHALL be 64x7 and is not reset; every job fully reloads it.
REQ-026 jam_Cost SHALL equal table[{jam_W,jam_J}] combinationally, with zero latency, in all states.
REQ-027 jam_rst SHALL be 1 in every state except RUN, decoded from the state register only.
REQ-028 RUN: a 20-bit watchdog starts at 0 on entry and increments each RUN cycle.
REQ-029 RUN, jam_Valid=1: capture jam_MinCost and jam_MatchCount into res_min_cost/res_match_count, set res_timeout=0, go to RESULT.
REQ-030 RUN, jam_Valid=0 with watchdog=TIMEOUT_CYC-1: go to RESULT with res_timeout=1; the result registers are left unchanged except res_timeout.
REQ-031 If jam_Valid and watchdog expiry coincide, jam_Valid wins (REQ-029).
REQ-032 RESULT: res_valid=1; res_min_cost, res_match_count and res_timeout SHALL hold stable until res_valid and res_ready are both 1.
REQ-033 On that res_valid/res_ready handshake: go to IDLE; res_valid=0 next cycle.
REQ-034 start outside IDLE SHALL be ignored; start is not queued.
REQ-035 Result registers SHALL keep their last values in IDLE, LOAD and RUN and update only per REQ-029/REQ-030.

Reset
REQ-036 RST=1 SHALL immediately, without a clock edge, force: state=IDLE, in_ready=0, res_valid=0, busy=0, jam_rst=1, res_min_cost=0, res_match_count=0, res_timeout=0, idx=0, watchdog=0.
REQ-037 Reset asserted mid-LOAD or mid-RUN SHALL abandon the job; no partial result is reported and the next job requires start plus all 64 words.

Verification
REQ-038 Assert RST asynchronously between clock edges -> all outputs take the REQ-036 values before the next edge.
REQ-039 Send start, then 64 words in_cost=(idx mod 128) with random in_valid gaps -> RUN is entered after the 64th accept; jam_W=3, jam_J=5 returns jam_Cost=29; jam_rst falls in the first RUN cycle.
REQ-040 Engine stub raises jam_Valid 100 cycles into RUN with MinCost=123, MatchCount=2 -> res_valid=1 next cycle with 123/2/timeout=0; hold res_ready=0 for 5 cycles (values stable), then pulse res_ready -> IDLE, jam_rst=1, busy=0.
REQ-041 With TIMEOUT_CYC=16 and jam_Valid held 0 -> res_valid rises exactly 16 cycles after RUN entry with res_timeout=1; jam_Valid and expiry coinciding -> res_timeout=0.
REQ-042 Assert RST after 30 words -> IDLE; a new start with only 30 words keeps the FSM in LOAD.
REQ-043 Pulse start during RUN and RESULT, and drive in_valid=1 in IDLE -> no state change and no table write.

Source files
------------

// File: rtl/jam_ctrl_if.sv
// Host-side bundle for jam_ctrl: job start, cost-word stream and result handshake.
// The controller takes the slave side; whoever feeds jobs takes the master side.
interface jam_ctrl_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_cost;
  logic       res_valid;
  logic       res_ready;
  logic [9:0] res_min_cost;
  logic [3:0] res_match_count;
  logic       res_timeout;
  logic       busy;

  modport master (
    output start, in_valid, in_cost, res_ready,
    input  in_ready, res_valid, res_min_cost, res_match_count, res_timeout, busy
  );

  modport slave (
    input  start, in_valid, in_cost, res_ready,
    output in_ready, res_valid, res_min_cost, res_match_count, res_timeout, busy
  );
endinterface

// File: rtl/jam_ctrl.sv
// Job controller for the JAM engine: loads a 64-entry cost table, runs the engine
// under a watchdog, and hands the captured result back over a valid/ready handshake.
module jam_ctrl #(
  parameter logic [19:0] TIMEOUT_CYC = 20'd1048575
) (
  input  logic       clk,
  input  logic       rst,
  jam_ctrl_if.slave  host,
  output logic       jam_rst,
  input  logic [2:0] jam_W,
  input  logic [2:0] jam_J,
  output logic [6:0] jam_Cost,
  input  logic [9:0] jam_MinCost,
  input  logic [3:0] jam_MatchCount,
  input  logic       jam_Valid
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESULT} state_t;

  localparam logic [19:0] WD_LAST = TIMEOUT_CYC - 20'd1;

  state_t      state;
  state_t      state_next;
  logic [5:0]  idx;
  logic [19:0] watchdog;
  logic [9:0]  min_cost_q;
  logic [3:0]  match_count_q;
  logic        timeout_q;
  logic [6:0]  cost_table [64];

  logic        in_ready;
  logic        res_valid;
  logic        busy;
  logic        accept;
  logic        expired;

  assign accept  = (state == LOAD) && host.in_valid;
  assign expired = (watchdog == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Status outputs depend on the state register alone, so reset forces them at once.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    jam_rst    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (host.start) state_next = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (host.in_valid && idx == 6'd63) state_next = RUN;
      end
      RUN: begin
        jam_rst = 1'b0;
        if (jam_Valid || expired) state_next = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (host.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // On a watchdog abort only the timeout flag moves; the previous costs stay visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      watchdog      <= '0;
      min_cost_q    <= '0;
      match_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx      <= '0;
          watchdog <= '0;
        end
        LOAD: begin
          if (host.in_valid) idx <= idx + 6'd1;
          watchdog <= '0;
        end
        RUN: begin
          watchdog <= watchdog + 20'd1;
          if (jam_Valid) begin
            min_cost_q    <= jam_MinCost;
            match_count_q <= jam_MatchCount;
            timeout_q     <= 1'b0;
          end else if (expired) begin
            timeout_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The table carries no reset: every job rewrites all 64 entries before RUN.
  always_ff @(posedge clk) begin
    if (accept) cost_table[idx] <= host.in_cost;
  end

  assign jam_Cost             = cost_table[{jam_W, jam_J}];
  assign host.in_ready        = in_ready;
  assign host.res_valid       = res_valid;
  assign host.busy            = busy;
  assign host.res_min_cost    = min_cost_q;
  assign host.res_match_count = match_count_q;
  assign host.res_timeout     = timeout_q;

endmodule

// File: tb/tb_jam_ctrl.sv
// Randomised bench for jam_ctrl: a job driver pushes the expected result of each job
// into a queue, and an independent monitor checks whatever the controller presents.
module tb_jam_ctrl;
  localparam logic [19:0] TO     = 20'd120;
  localparam int          TO_INT = 120;

  typedef struct packed {
    logic [9:0] min_cost;
    logic [3:0] match_count;
    logic       timeout;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       jam_rst;
  logic [2:0] jam_W = '0;
  logic [2:0] jam_J = '0;
  logic [6:0] jam_Cost;
  logic [9:0] jam_MinCost = '0;
  logic [3:0] jam_MatchCount = '0;
  logic       jam_Valid = 1'b0;

  jam_ctrl_if intf ();

  jam_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .host           (intf),
    .jam_rst        (jam_rst),
    .jam_W          (jam_W),
    .jam_J          (jam_J),
    .jam_Cost       (jam_Cost),
    .jam_MinCost    (jam_MinCost),
    .jam_MatchCount (jam_MatchCount),
    .jam_Valid      (jam_Valid)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [6:0] model_table [64];
  res_t       model_res = '0;
  res_t       exp_q [$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle a result is shown it must match the oldest outstanding job.
  always @(negedge clk) begin
    if (!rst && intf.res_valid) begin
      if (exp_q.size() == 0) begin
        check_output("result with empty scoreboard", 32'd1, 32'd0);
      end else begin
        check_output("res_min_cost", 32'(intf.res_min_cost), 32'(exp_q[0].min_cost));
        check_output("res_match_count", 32'(intf.res_match_count), 32'(exp_q[0].match_count));
        check_output("res_timeout", 32'(intf.res_timeout), 32'(exp_q[0].timeout));
        if (intf.res_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check_output({tag, " in_ready"}, 32'(intf.in_ready), 32'd0);
    check_output({tag, " res_valid"}, 32'(intf.res_valid), 32'd0);
    check_output({tag, " busy"}, 32'(intf.busy), 32'd0);
    check_output({tag, " jam_rst"}, 32'(jam_rst), 32'd1);
    check_output({tag, " res_min_cost"}, 32'(intf.res_min_cost), 32'd0);
    check_output({tag, " res_match_count"}, 32'(intf.res_match_count), 32'd0);
    check_output({tag, " res_timeout"}, 32'(intf.res_timeout), 32'd0);
  endtask

  // Reset is raised between edges and the outputs are checked before the next edge.
  task automatic reset_mid_cycle(input string tag);
    intf.in_valid = 1'b0;
    jam_Valid     = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    model_res = '0;
    tick;
    rst = 1'b0;
  endtask

  task automatic start_job;
    intf.start = 1'b1;
    tick;
    intf.start = 1'b0;
    check_output("load entry busy", 32'(intf.busy), 32'd1);
    check_output("load entry in_ready", 32'(intf.in_ready), 32'd1);
  endtask

  task automatic load_words(input int first, input int n, input bit ramp);
    for (int i = first; i < first + n; i++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      intf.in_valid = 1'b0;
      repeat (gaps) tick;
      intf.in_valid = 1'b1;
      intf.in_cost  = ramp ? 7'(i % 128) : 7'($urandom_range(0, 127));
      model_table[i] = intf.in_cost;
      tick;
    end
    intf.in_valid = 1'b0;
  endtask

  // Engine stub raises jam_Valid in RUN cycle 'delay' (0 = first RUN cycle).
  task automatic run_job(input int delay, input logic [9:0] mc, input logic [3:0] cnt,
                         input int hold, input bit poke);
    res_t e;
    int   run_cycles;
    if (delay < TO_INT) begin
      e          = '{min_cost: mc, match_count: cnt, timeout: 1'b0};
      run_cycles = delay + 1;
    end else begin
      e          = model_res;
      e.timeout  = 1'b1;
      run_cycles = TO_INT;
    end
    model_res = e;
    exp_q.push_back(e);

    check_output("run entry in_ready", 32'(intf.in_ready), 32'd0);
    check_output("run entry jam_rst", 32'(jam_rst), 32'd0);
    check_output("run entry busy", 32'(intf.busy), 32'd1);

    for (int k = 0; k < run_cycles; k++) begin
      jam_Valid      = (k == delay);
      jam_MinCost    = (k == delay) ? mc : 10'($urandom_range(0, 1023));
      jam_MatchCount = (k == delay) ? cnt : 4'($urandom_range(0, 15));
      jam_W          = (k == 0) ? 3'd3 : 3'($urandom_range(0, 7));
      jam_J          = (k == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      intf.start     = poke && (k == 2);
      #1;
      if (k < 4) check_output("jam_Cost lookup", 32'(jam_Cost), 32'(model_table[{jam_W, jam_J}]));
      tick;
    end
    jam_Valid  = 1'b0;
    intf.start = 1'b0;

    check_output("result valid timing", 32'(intf.res_valid), 32'd1);
    check_output("result jam_rst", 32'(jam_rst), 32'd1);

    for (int h = 0; h < hold; h++) begin
      intf.start = poke;
      tick;
    end
    intf.start     = 1'b0;
    intf.res_ready = 1'b1;
    tick;
    intf.res_ready = 1'b0;
    check_output("post handshake res_valid", 32'(intf.res_valid), 32'd0);
    check_output("post handshake busy", 32'(intf.busy), 32'd0);
    check_output("post handshake jam_rst", 32'(jam_rst), 32'd1);
  endtask

  // IDLE must ignore cost words and engine results alike.
  task automatic idle_poke;
    for (int c = 0; c < 4; c++) begin
      intf.in_valid = 1'b1;
      intf.in_cost  = 7'($urandom_range(0, 127));
      jam_Valid     = 1'b1;
      jam_MinCost   = 10'($urandom_range(0, 1023));
      jam_W         = 3'($urandom_range(0, 7));
      jam_J         = 3'($urandom_range(0, 7));
      #1;
      check_output("idle table intact", 32'(jam_Cost), 32'(model_table[{jam_W, jam_J}]));
      tick;
      check_output("idle busy", 32'(intf.busy), 32'd0);
      check_output("idle in_ready", 32'(intf.in_ready), 32'd0);
      check_output("idle res_min_cost", 32'(intf.res_min_cost), 32'(model_res.min_cost));
      check_output("idle res_timeout", 32'(intf.res_timeout), 32'(model_res.timeout));
    end
    intf.in_valid = 1'b0;
    jam_Valid     = 1'b0;
  endtask

  initial begin
    intf.start     = 1'b0;
    intf.in_valid  = 1'b0;
    intf.in_cost   = '0;
    intf.res_ready = 1'b0;

    #2;
    rst = 1'b1;
    #1;
    check_reset_values("power-on reset");
    tick;
    tick;
    rst = 1'b0;

    // Ramp job: word i carries i, so W=3,J=5 must look up 29.
    start_job;
    load_words(0, 64, 1'b1);
    run_job(100, 10'd123, 4'd2, 5, 1'b1);
    idle_poke;

    // Watchdog abort, then jam_Valid landing on the expiry cycle.
    start_job;
    load_words(0, 64, 1'b0);
    run_job(1000, 10'd999, 4'd9, $urandom_range(0, 4), 1'b0);
    start_job;
    load_words(0, 64, 1'b0);
    run_job(TO_INT - 1, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 2, 1'b1);

    // Abandon a load after 30 words; 30 words of a fresh job must not reach RUN.
    start_job;
    load_words(0, 30, 1'b0);
    reset_mid_cycle("reset mid-load");
    start_job;
    load_words(0, 30, 1'b0);
    repeat (3) begin
      tick;
      check_output("partial load busy", 32'(intf.busy), 32'd1);
      check_output("partial load in_ready", 32'(intf.in_ready), 32'd1);
      check_output("partial load jam_rst", 32'(jam_rst), 32'd1);
    end
    load_words(30, 34, 1'b0);
    run_job(50, 10'd517, 4'd7, 1, 1'b0);

    // Abandon a run: no result may appear for it.
    start_job;
    load_words(0, 64, 1'b0);
    repeat (5) tick;
    reset_mid_cycle("reset mid-run");

    for (int j = 0; j < 4; j++) begin
      start_job;
      load_words(0, 64, 1'b0);
      run_job($urandom_range(0, TO_INT + 20), 10'($urandom_range(0, 1023)),
              4'($urandom_range(0, 15)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      idle_poke;
    end

    tick;
    check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
